// File: rtl/fc_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
package fc_pkg;

  localparam int unsigned PC_W_DEF   = 13;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned ST_W_DEF   = 2;

  localparam logic [INST_W_DEF-1:0] BUBBLE_INST = '0;

  // Layout matches the packed storage word in fc_queue: {pc, inst, state}.
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic [ST_W_DEF-1:0]   state;
  } fc_entry_t;

endpackage

// File: rtl/fc_queue_mem.sv
// Entry storage for fc_queue: synchronous write, asynchronous read, no data reset.
module fc_queue_mem #(
  parameter int unsigned WIDTH = 47,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fc_queue.sv
// Fetch-to-decode instruction queue with flush and input squash.
// Optional zero-latency bypass when empty: define FC_QUEUE_BYPASS_EN.
module fc_queue
  import fc_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned ST_W   = ST_W_DEF,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ST_W-1:0]   in_state,
  input  logic              squash_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [ST_W-1:0]   out_state,
  output logic [CW-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = PC_W + INST_W + ST_W;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] wdata, rdata;
  logic          has_head, bypass, enq, deq;

  assign has_head = (count_q != '0);
  assign in_ready = (count_q < CW'(DEPTH));

`ifdef FC_QUEUE_BYPASS_EN
  // Empty queue with a consumer ready: hand the input straight through.
  assign bypass = ~has_head & in_valid & ~squash_in & ~flush & out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign enq = in_valid & in_ready & ~squash_in & ~flush & ~bypass;
  assign deq = has_head & out_ready & ~flush;

  always_comb begin
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign wdata = {in_pc, in_inst, in_state};

  fc_queue_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    out_valid = has_head | bypass;
    out_pc    = '0;
    out_inst  = INST_W'(BUBBLE_INST);
    out_state = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_inst  = in_inst;
      out_state = in_state;
    end else if (has_head) begin
      out_pc    = rdata[EW-1 -: PC_W];
      out_inst  = rdata[ST_W +: INST_W];
      out_state = rdata[ST_W-1:0];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fc_queue.sv
// Self-checking bench for fc_queue against a queue-based reference model.
module tb_fc_queue;
  import fc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  in_valid, in_ready, squash_in, flush;
  logic                  out_valid, out_ready;
  logic [PC_W_DEF-1:0]   in_pc, out_pc;
  logic [INST_W_DEF-1:0] in_inst, out_inst;
  logic [ST_W_DEF-1:0]   in_state, out_state;
  logic [CW-1:0]         count;

  fc_queue #(
    .PC_W   (PC_W_DEF),
    .INST_W (INST_W_DEF),
    .ST_W   (ST_W_DEF),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_state  (in_state),
    .squash_in (squash_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_state (out_state),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  fc_entry_t model_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance model at the edge.
  task automatic step(input logic iv, input logic [PC_W_DEF-1:0] pc,
                      input logic [INST_W_DEF-1:0] inst, input logic [ST_W_DEF-1:0] st,
                      input logic sq, input logic fl, input logic ordy, input logic rst);
    fc_entry_t head;
    logic      byp, exp_valid, can_enq;
    int        sz;
    RST       = rst;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    in_state  = st;
    squash_in = sq;
    flush     = fl;
    out_ready = ordy;
    #1;
    sz  = model_q.size();
    byp = 1'b0;
`ifdef FC_QUEUE_BYPASS_EN
    byp = (sz == 0) && iv && !sq && !fl && ordy;
`endif
    exp_valid = (sz > 0) || byp;
    head = '0;
    if (byp) begin
      head.pc    = pc;
      head.inst  = inst;
      head.state = st;
    end else if (sz > 0) begin
      head = model_q[0];
    end
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("in_ready",  64'(in_ready),  64'(sz < DEPTH));
    check("count",     64'(count),     64'(sz));
    check("out_pc",    64'(out_pc),    64'(head.pc));
    check("out_inst",  64'(out_inst),  64'(head.inst));
    check("out_state", 64'(out_state), 64'(head.state));
    can_enq = iv && !sq && (sz < DEPTH);
    @(posedge CLK);
    if (rst || fl) begin
      model_q.delete();
    end else if (!byp) begin
      if (ordy && sz > 0) void'(model_q.pop_front());
      if (can_enq) begin
        head.pc    = pc;
        head.inst  = inst;
        head.state = st;
        model_q.push_back(head);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [PC_W_DEF-1:0] hold_pc;
    RST = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_state = '0;
    squash_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(1'b0);

    // Fill to full, then a fifth push that must be ignored.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, PC_W_DEF'(4 + 4 * k), 32'h0010_0093 + 32'(k), ST_W_DEF'(k), 1'b0, 1'b0,
           1'b0, 1'b0);
    end
    check("full_head_pc", 64'(out_pc), 64'h004);
    idle(1'b0);

    // Flush while full with a live input.
    step(1'b1, 13'h018, 32'hdead_beef, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_inst", 64'(out_inst), 64'(BUBBLE_INST));
    idle(1'b1);

    // Continuous push and pop across the pointer wrap.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, PC_W_DEF'(4 + 4 * k), 32'h0010_0093 + 32'(k), ST_W_DEF'(k), 1'b0, 1'b0,
           1'b1, 1'b0);
    end
    idle(1'b1);

    // Squash incoming 0x020 while popping 0x01C.
    step(1'b1, 13'h01c, 32'h0000_0013, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 13'h020, 32'h0000_0033, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    check("squash_pc", 64'(out_pc), 64'h000);
    idle(1'b1);

    // Backpressure hold, then reset mid-hold.
    step(1'b1, 13'h040, 32'h0040_0093, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_pc = out_pc;
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      check("hold_pc", 64'(out_pc), 64'(hold_pc));
    end
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, PC_W_DEF'($urandom), $urandom, ST_W_DEF'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
